// File: rtl/mantissa_normalizer_if.sv
// Valid/ready bus around the mantissa normalizer: raw pair in, normalized pair plus flags out.
// The normalizer sits on the slave side; the producer/consumer pair sits on the master side.
interface mantissa_normalizer_if #(
    parameter int WORD_SIZE = 24,
    parameter int EXP_W     = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_mant;
    logic [EXP_W-1:0]     in_exp;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_mant;
    logic [EXP_W-1:0]     out_exp;
    logic [EXP_W-1:0]     out_shift;
    logic                 out_zero;
    logic                 out_uflow;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow
    );
endinterface

// File: rtl/mantissa_normalizer.sv
// Iterative normalizer: shifts the mantissa left one bit per cycle until the hidden bit is set,
// decrementing the exponent per shift and stopping early on a zero mantissa or exponent underflow.
module mantissa_normalizer #(
    parameter int WORD_SIZE = 24,
    parameter int EXP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    mantissa_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [WORD_SIZE-1:0] mant_r, mant_nxt;
    logic [EXP_W-1:0]     exp_r, exp_nxt;
    logic [EXP_W-1:0]     cnt_r, cnt_nxt;
    logic                 zero_r, zero_nxt;
    logic                 uflow_r, uflow_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            mant_r  <= '0;
            exp_r   <= '0;
            cnt_r   <= '0;
            zero_r  <= 1'b0;
            uflow_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            mant_r  <= mant_nxt;
            exp_r   <= exp_nxt;
            cnt_r   <= cnt_nxt;
            zero_r  <= zero_nxt;
            uflow_r <= uflow_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mant_nxt  = mant_r;
        exp_nxt   = exp_r;
        cnt_nxt   = cnt_r;
        zero_nxt  = zero_r;
        uflow_nxt = uflow_r;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    mant_nxt  = bus.in_mant;
                    exp_nxt   = bus.in_exp;
                    cnt_nxt   = '0;
                    zero_nxt  = 1'b0;
                    uflow_nxt = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Checks are ordered so the exponent is tested before it could ever wrap.
                if (mant_r == '0) begin
                    zero_nxt  = 1'b1;
                    exp_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (mant_r[WORD_SIZE-1]) begin
                    state_nxt = DONE;
                end else if (exp_r == '0) begin
                    uflow_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    mant_nxt = {mant_r[WORD_SIZE-2:0], 1'b0};
                    exp_nxt  = exp_r - EXP_W'(1);
                    cnt_nxt  = cnt_r + EXP_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_mant  = mant_r;
    assign bus.out_exp   = exp_r;
    assign bus.out_shift = cnt_r;
    assign bus.out_zero  = zero_r;
    assign bus.out_uflow = uflow_r;

endmodule
